exemem_reg: RTL and testbench
=============================

EXEMEM_REG -- requirements
Module: exemem_reg

Interface
REQ-001 SHALL have parameter BCNT_W, default 16, width of the saturating bubble counter.
REQ-002 SHALL have port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, in, 1: synchronous active-high reset (1 = reset), sampled on the rising edge of clk.
REQ-004 SHALL have port stall, in, 2: bit0 = exe stage stalled, bit1 = mem stage stalled.
REQ-005 SHALL have port flush, in, 1: exception/redirect kill of all in-flight state.
REQ-006 SHALL have port exe_slot2_v_i, in, 1: exe slot 2 holds an issued instruction.
REQ-007 SHALL have ports inst{1,2}_result_i, in, 32 each: exe ALU results per slot.
REQ-008 SHALL have ports inst{1,2}_memtype_i, in, 8 each: memory-access type per slot.
REQ-009 SHALL have ports inst{1,2}_mreg_i, in, 1 each: result comes from memory.
REQ-010 SHALL have ports inst{1,2}_whilo_i, in, 2 each: HI/LO write enables.
REQ-011 SHALL have ports inst{1,2}_wreg_i, in, 1 each; inst{1,2}_wa_i, in, 5 each: GPR write enable/address.
REQ-012 SHALL have ports inst{1,2}_din_i, in, 32 each: store data.
REQ-013 SHALL have ports aluop_i, in, 8; mulres_i, in, 64; exccode_i, in, 5: slot-1 op, mul/div result, exception code.
REQ-014 SHALL have matching registered outputs with suffix _o for every _i port in REQ-006..REQ-013 (exe_slot2_v_i becomes mem_slot2_v_o).
REQ-015 SHALL have port mem_v_o, out, 1: mem stage holds a valid (non-bubble) slot-1 instruction.
REQ-016 SHALL have port bubble_cnt_o, out, BCNT_W: count of bubbles inserted since reset.

Function
REQ-017 SHALL compute each cycle, in priority order: reset, flush, hold, bubble, load.
REQ-018 Hold (stall[1]=1, no reset/flush) SHALL keep every output register unchanged.
REQ-019 Bubble (stall[0]=1, stall[1]=0) SHALL clear all outputs to 0 and set exccode_o to EXC_NONE.
REQ-020 Load (stall=2'b00) SHALL copy every input to its output, set mem_v_o=1, and set mem_slot2_v_o=exe_slot2_v_i.
REQ-021 Load with exe_slot2_v_i=0 SHALL force inst2_wreg_o=0, inst2_whilo_o=0 and inst2_memtype_o=0, whatever the other slot-2 inputs are.
REQ-022 Load SHALL have latency of exactly one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-023 Flush SHALL clear all outputs to 0, mem_v_o to 0 and exccode_o to EXC_NONE, even when stall[1]=1.
REQ-024 Flush SHALL NOT increment bubble_cnt_o.
REQ-025 Each bubble cycle SHALL increment bubble_cnt_o by 1, saturating at all-ones with no wrap.
REQ-026 Holding over a bubble SHALL NOT increment bubble_cnt_o again.
REQ-027 stall=2'b10 (mem only) SHALL be treated as a hold.
REQ-028 Results and flags SHALL pass through unmodified, with no arithmetic applied; mulres_o SHALL be the full 64 bits.

Reset
REQ-029 Under resetn=1, all outputs including bubble_cnt_o SHALL clear to 0 (exccode_o=EXC_NONE) on the next edge, overriding flush and stall.
REQ-030 Reset asserted mid-hold SHALL discard the held instruction; the first load after release SHALL behave as REQ-020.

Verification
REQ-031 Reset, then load inst1_result_i=0x1234_5678, wa=5'd3, wreg=1, stall=0 -> next cycle inst1_result_o=0x12345678, inst1_wa_o=3, mem_v_o=1.
REQ-032 Load with exe_slot2_v_i=0, inst2_wreg_i=1, inst2_whilo_i=2'b11 -> inst2_wreg_o=0, inst2_whilo_o=0, mem_slot2_v_o=0.
REQ-033 stall=2'b01 for 3 cycles -> outputs 0, mem_v_o=0, bubble_cnt_o=3; then stall=2'b11 for 2 cycles -> bubble_cnt_o stays 3.
REQ-034 Valid instruction held with stall=2'b11, flush=1 pulsed -> next cycle all outputs 0, mem_v_o=0, bubble_cnt_o unchanged.
REQ-035 Preload bubble_cnt_o to all-ones via 2^BCNT_W bubbles (BCNT_W=4: 16 bubbles) -> stays 4'hF on further bubbles.
REQ-036 mulres_i=64'hFFFF_0000_DEAD_BEEF loaded, then resetn=1 with flush=0, stall=2'b11 -> mulres_o=0 and bubble_cnt_o=0 next cycle.

Source files
------------

// File: rtl/exemem_reg_if.sv
// exemem_reg_if: exe->mem pipeline register bundle
// stall/flush plus every exe-stage field (_i) and its registered mem-stage copy (_o).
// master = exe-side driver, slave = the pipeline register itself.
interface exemem_reg_if #(parameter int BCNT_W = 16);
  logic [1:0]        stall;
  logic              flush;
  logic              exe_slot2_v_i;
  logic [31:0]       inst1_result_i, inst2_result_i;
  logic [7:0]        inst1_memtype_i, inst2_memtype_i;
  logic              inst1_mreg_i, inst2_mreg_i;
  logic [1:0]        inst1_whilo_i, inst2_whilo_i;
  logic              inst1_wreg_i, inst2_wreg_i;
  logic [4:0]        inst1_wa_i, inst2_wa_i;
  logic [31:0]       inst1_din_i, inst2_din_i;
  logic [7:0]        aluop_i;
  logic [63:0]       mulres_i;
  logic [4:0]        exccode_i;
  logic              mem_slot2_v_o;
  logic [31:0]       inst1_result_o, inst2_result_o;
  logic [7:0]        inst1_memtype_o, inst2_memtype_o;
  logic              inst1_mreg_o, inst2_mreg_o;
  logic [1:0]        inst1_whilo_o, inst2_whilo_o;
  logic              inst1_wreg_o, inst2_wreg_o;
  logic [4:0]        inst1_wa_o, inst2_wa_o;
  logic [31:0]       inst1_din_o, inst2_din_o;
  logic [7:0]        aluop_o;
  logic [63:0]       mulres_o;
  logic [4:0]        exccode_o;
  logic              mem_v_o;
  logic [BCNT_W-1:0] bubble_cnt_o;
  modport master (
    output stall, flush, exe_slot2_v_i, inst1_result_i, inst2_result_i, inst1_memtype_i, inst2_memtype_i,
           inst1_mreg_i, inst2_mreg_i, inst1_whilo_i, inst2_whilo_i, inst1_wreg_i, inst2_wreg_i,
           inst1_wa_i, inst2_wa_i, inst1_din_i, inst2_din_i, aluop_i, mulres_i, exccode_i,
    input  mem_slot2_v_o, inst1_result_o, inst2_result_o, inst1_memtype_o, inst2_memtype_o,
           inst1_mreg_o, inst2_mreg_o, inst1_whilo_o, inst2_whilo_o, inst1_wreg_o, inst2_wreg_o,
           inst1_wa_o, inst2_wa_o, inst1_din_o, inst2_din_o, aluop_o, mulres_o, exccode_o,
           mem_v_o, bubble_cnt_o
  );
  modport slave (
    input  stall, flush, exe_slot2_v_i, inst1_result_i, inst2_result_i, inst1_memtype_i, inst2_memtype_i,
           inst1_mreg_i, inst2_mreg_i, inst1_whilo_i, inst2_whilo_i, inst1_wreg_i, inst2_wreg_i,
           inst1_wa_i, inst2_wa_i, inst1_din_i, inst2_din_i, aluop_i, mulres_i, exccode_i,
    output mem_slot2_v_o, inst1_result_o, inst2_result_o, inst1_memtype_o, inst2_memtype_o,
           inst1_mreg_o, inst2_mreg_o, inst1_whilo_o, inst2_whilo_o, inst1_wreg_o, inst2_wreg_o,
           inst1_wa_o, inst2_wa_o, inst1_din_o, inst2_din_o, aluop_o, mulres_o, exccode_o,
           mem_v_o, bubble_cnt_o
  );
endinterface

// File: rtl/exemem_reg.sv
// exemem_reg: exe->mem dual-issue pipeline register with hold/bubble/flush and bubble counter
// clk, resetn (sync, active-high) plain; everything else via exemem_reg_if.slave b.
module exemem_reg #(parameter int BCNT_W = 16) (
  input logic clk,
  input logic resetn,
  exemem_reg_if.slave b
);
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam int W = 241;
  localparam logic [W-1:0] CLR = {235'b0, EXC_NONE, 1'b0};
  logic [W-1:0] r_q;
  logic [W-1:0] w_d;
  logic [BCNT_W-1:0] r_bcnt;
  logic w_s2;
  logic w_bubble;
  assign w_s2 = b.exe_slot2_v_i;
  assign w_bubble = !b.flush && b.stall == 2'b01;
  // slot-2 side effects are masked when no slot-2 instruction was issued
  assign w_d = {w_s2, b.inst1_result_i, b.inst2_result_i, b.inst1_memtype_i, b.inst2_memtype_i & {8{w_s2}},
                b.inst1_mreg_i, b.inst2_mreg_i, b.inst1_whilo_i, b.inst2_whilo_i & {2{w_s2}},
                b.inst1_wreg_i, b.inst2_wreg_i & w_s2, b.inst1_wa_i, b.inst2_wa_i,
                b.inst1_din_i, b.inst2_din_i, b.aluop_i, b.mulres_i, b.exccode_i, 1'b1};
  assign {b.mem_slot2_v_o, b.inst1_result_o, b.inst2_result_o, b.inst1_memtype_o, b.inst2_memtype_o,
          b.inst1_mreg_o, b.inst2_mreg_o, b.inst1_whilo_o, b.inst2_whilo_o,
          b.inst1_wreg_o, b.inst2_wreg_o, b.inst1_wa_o, b.inst2_wa_o,
          b.inst1_din_o, b.inst2_din_o, b.aluop_o, b.mulres_o, b.exccode_o, b.mem_v_o} = r_q;
  assign b.bubble_cnt_o = r_bcnt;
  always_ff @(posedge clk)
    if (resetn || b.flush) r_q <= CLR;
    else if (!b.stall[1]) r_q <= b.stall[0] ? CLR : w_d;
  always_ff @(posedge clk)
    if (resetn) r_bcnt <= '0;
    else if (w_bubble && !(&r_bcnt)) r_bcnt <= r_bcnt + 1'b1;
endmodule

// File: tb/tb_exemem_reg.sv
// tb_exemem_reg: vector table + hand sequences + randomized run against a field-level model
module tb_exemem_reg;
  localparam int BW = 4;
  localparam int BMAX = (1 << BW) - 1;
  localparam logic [4:0] EXC_NONE = 5'h10;
  logic clk = 0;
  logic resetn = 1;
  int checks = 0;
  int errors = 0;
  exemem_reg_if #(.BCNT_W(BW)) b();
  exemem_reg #(.BCNT_W(BW)) dut (.clk(clk), .resetn(resetn), .b(b));
  always #5 clk = ~clk;

  typedef struct {
    logic s2v; logic [31:0] r1, r2; logic [7:0] mt1, mt2; logic mr1, mr2;
    logic [1:0] wh1, wh2; logic wr1, wr2; logic [4:0] wa1, wa2; logic [31:0] d1, d2;
    logic [7:0] alu; logic [63:0] mul; logic [4:0] exc; logic mv; int bc;
  } st_t;
  st_t m;

  typedef struct {
    logic rst, fl; logic [1:0] st; logic s2v, wr1, wr2; logic [1:0] wh2; logic [4:0] wa1;
    logic [31:0] r1; logic [63:0] mul;
    logic e_mv, e_s2v, e_wr2; logic [1:0] e_wh2; logic [4:0] e_wa1; logic [31:0] e_r1;
    logic [63:0] e_mul; int e_bc;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic st_t cleared(input int bc);
    st_t s = '{default: 0};
    s.exc = EXC_NONE;
    s.bc = bc;
    return s;
  endfunction

  // advance the model by one edge using the currently applied inputs
  task automatic model_step();
    if (resetn) m = cleared(0);
    else if (b.flush) m = cleared(m.bc);
    else if (b.stall[1]) m = m;
    else if (b.stall[0]) m = cleared(m.bc < BMAX ? m.bc + 1 : BMAX);
    else begin
      m.s2v = b.exe_slot2_v_i;
      m.r1 = b.inst1_result_i; m.r2 = b.inst2_result_i;
      m.mt1 = b.inst1_memtype_i; m.mt2 = b.exe_slot2_v_i ? b.inst2_memtype_i : 8'd0;
      m.mr1 = b.inst1_mreg_i; m.mr2 = b.inst2_mreg_i;
      m.wh1 = b.inst1_whilo_i; m.wh2 = b.exe_slot2_v_i ? b.inst2_whilo_i : 2'd0;
      m.wr1 = b.inst1_wreg_i; m.wr2 = b.exe_slot2_v_i ? b.inst2_wreg_i : 1'b0;
      m.wa1 = b.inst1_wa_i; m.wa2 = b.inst2_wa_i;
      m.d1 = b.inst1_din_i; m.d2 = b.inst2_din_i;
      m.alu = b.aluop_i; m.mul = b.mulres_i; m.exc = b.exccode_i; m.mv = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("mem_slot2_v", b.mem_slot2_v_o, m.s2v);
    chk("inst1_result", b.inst1_result_o, m.r1);
    chk("inst2_result", b.inst2_result_o, m.r2);
    chk("inst1_memtype", b.inst1_memtype_o, m.mt1);
    chk("inst2_memtype", b.inst2_memtype_o, m.mt2);
    chk("inst1_mreg", b.inst1_mreg_o, m.mr1);
    chk("inst2_mreg", b.inst2_mreg_o, m.mr2);
    chk("inst1_whilo", b.inst1_whilo_o, m.wh1);
    chk("inst2_whilo", b.inst2_whilo_o, m.wh2);
    chk("inst1_wreg", b.inst1_wreg_o, m.wr1);
    chk("inst2_wreg", b.inst2_wreg_o, m.wr2);
    chk("inst1_wa", b.inst1_wa_o, m.wa1);
    chk("inst2_wa", b.inst2_wa_o, m.wa2);
    chk("inst1_din", b.inst1_din_o, m.d1);
    chk("inst2_din", b.inst2_din_o, m.d2);
    chk("aluop", b.aluop_o, m.alu);
    chk("mulres", b.mulres_o, m.mul);
    chk("exccode", b.exccode_o, m.exc);
    chk("mem_v", b.mem_v_o, m.mv);
    chk("bubble_cnt", b.bubble_cnt_o, 64'(m.bc));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic zero_inputs();
    b.stall = 0; b.flush = 0; b.exe_slot2_v_i = 0;
    b.inst1_result_i = 0; b.inst2_result_i = 0; b.inst1_memtype_i = 0; b.inst2_memtype_i = 0;
    b.inst1_mreg_i = 0; b.inst2_mreg_i = 0; b.inst1_whilo_i = 0; b.inst2_whilo_i = 0;
    b.inst1_wreg_i = 0; b.inst2_wreg_i = 0; b.inst1_wa_i = 0; b.inst2_wa_i = 0;
    b.inst1_din_i = 0; b.inst2_din_i = 0; b.aluop_i = 0; b.mulres_i = 0; b.exccode_i = 0;
  endtask

  task automatic rand_inputs();
    b.exe_slot2_v_i = 1'($urandom);
    b.inst1_result_i = $urandom; b.inst2_result_i = $urandom;
    b.inst1_memtype_i = 8'($urandom); b.inst2_memtype_i = 8'($urandom);
    b.inst1_mreg_i = 1'($urandom); b.inst2_mreg_i = 1'($urandom);
    b.inst1_whilo_i = 2'($urandom); b.inst2_whilo_i = 2'($urandom);
    b.inst1_wreg_i = 1'($urandom); b.inst2_wreg_i = 1'($urandom);
    b.inst1_wa_i = 5'($urandom); b.inst2_wa_i = 5'($urandom);
    b.inst1_din_i = $urandom; b.inst2_din_i = $urandom;
    b.aluop_i = 8'($urandom); b.mulres_i = {$urandom, $urandom}; b.exccode_i = 5'($urandom);
    b.stall = 2'($urandom_range(0, 3));
    b.flush = ($urandom_range(0, 7) == 0);
    resetn = ($urandom_range(0, 31) == 0);
  endtask

  vec_t v[18];

  initial begin
    //        rst fl st     s2v wr1 wr2 wh2   wa1 r1            mul                     mv s2v wr2 wh2   wa1 r1            mul                     bc
    v[0]  = '{1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  0};
    v[1]  = '{0, 0, 2'b00, 1, 1, 1, 2'b01, 3, 32'h12345678, 64'h0,                  1, 1, 1, 2'b01, 3, 32'h12345678, 64'h0,                  0};
    v[2]  = '{0, 0, 2'b00, 0, 1, 1, 2'b11, 7, 32'hAAAA0000, 64'h0,                  1, 0, 0, 2'b00, 7, 32'hAAAA0000, 64'h0,                  0};
    v[3]  = '{0, 0, 2'b01, 1, 1, 1, 2'b11, 1, 32'h1111,     64'h1,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  1};
    v[4]  = '{0, 0, 2'b01, 1, 1, 1, 2'b11, 1, 32'h1111,     64'h1,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  2};
    v[5]  = '{0, 0, 2'b01, 1, 1, 1, 2'b11, 1, 32'h1111,     64'h1,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  3};
    v[6]  = '{0, 0, 2'b11, 1, 1, 1, 2'b11, 1, 32'h1111,     64'h1,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  3};
    v[7]  = '{0, 0, 2'b11, 1, 1, 1, 2'b11, 1, 32'h1111,     64'h1,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  3};
    v[8]  = '{0, 0, 2'b00, 1, 1, 0, 2'b10, 9, 32'hCAFEF00D, 64'h2,                  1, 1, 0, 2'b10, 9, 32'hCAFEF00D, 64'h2,                  3};
    v[9]  = '{0, 0, 2'b11, 0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  1, 1, 0, 2'b10, 9, 32'hCAFEF00D, 64'h2,                  3};
    v[10] = '{0, 1, 2'b11, 1, 1, 1, 2'b11, 4, 32'h44,       64'h4,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  3};
    v[11] = '{0, 0, 2'b00, 1, 1, 1, 2'b01, 1, 32'h1,        64'hFFFF0000DEADBEEF,   1, 1, 1, 2'b01, 1, 32'h1,        64'hFFFF0000DEADBEEF,   3};
    v[12] = '{1, 0, 2'b11, 1, 1, 1, 2'b01, 1, 32'h1,        64'hFFFF0000DEADBEEF,   0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  0};
    v[13] = '{0, 0, 2'b10, 1, 1, 1, 2'b01, 2, 32'h2,        64'h2,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  0};
    v[14] = '{0, 0, 2'b00, 1, 1, 1, 2'b11, 5, 32'h5,        64'h5,                  1, 1, 1, 2'b11, 5, 32'h5,        64'h5,                  0};
    v[15] = '{0, 0, 2'b11, 0, 0, 0, 2'b00, 6, 32'h6,        64'h6,                  1, 1, 1, 2'b11, 5, 32'h5,        64'h5,                  0};
    v[16] = '{1, 0, 2'b11, 0, 0, 0, 2'b00, 6, 32'h6,        64'h6,                  0, 0, 0, 2'b00, 0, 32'h0,        64'h0,                  0};
    v[17] = '{0, 0, 2'b00, 1, 1, 1, 2'b10, 8, 32'h88,       64'h88,                 1, 1, 1, 2'b10, 8, 32'h88,       64'h88,                 0};
    zero_inputs();
    m = cleared(0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      zero_inputs();
      resetn = v[i].rst; b.flush = v[i].fl; b.stall = v[i].st; b.exe_slot2_v_i = v[i].s2v;
      b.inst1_wreg_i = v[i].wr1; b.inst2_wreg_i = v[i].wr2; b.inst2_whilo_i = v[i].wh2;
      b.inst1_wa_i = v[i].wa1; b.inst1_result_i = v[i].r1; b.mulres_i = v[i].mul;
      step();
      chk($sformatf("v%0d mem_v", i), b.mem_v_o, v[i].e_mv);
      chk($sformatf("v%0d mem_slot2_v", i), b.mem_slot2_v_o, v[i].e_s2v);
      chk($sformatf("v%0d inst2_wreg", i), b.inst2_wreg_o, v[i].e_wr2);
      chk($sformatf("v%0d inst2_whilo", i), b.inst2_whilo_o, v[i].e_wh2);
      chk($sformatf("v%0d inst1_wa", i), b.inst1_wa_o, v[i].e_wa1);
      chk($sformatf("v%0d inst1_result", i), b.inst1_result_o, v[i].e_r1);
      chk($sformatf("v%0d mulres", i), b.mulres_o, v[i].e_mul);
      chk($sformatf("v%0d bubble_cnt", i), b.bubble_cnt_o, 64'(v[i].e_bc));
    end
    zero_inputs();
    resetn = 1;
    step();
    resetn = 0;
    b.stall = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat bubble %0d", i), b.bubble_cnt_o, 64'(i < BMAX ? i : BMAX));
    end
    b.stall = 2'b00;
    b.inst1_result_i = 32'h77;
    step();
    chk("sat load exccode", b.exccode_o, 64'(b.exccode_i));
    b.stall = 2'b01;
    step();
    chk("sat post bubble", b.bubble_cnt_o, 64'(BMAX));
    b.flush = 1;
    step();
    chk("flush exccode", b.exccode_o, 64'(EXC_NONE));
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
